pes_bcd7seg_scan: RTL and testbench
===================================

# pes_bcd7seg_scan

Two-digit multiplexed seven-segment display driver that sits directly downstream of the 8-bit BCD counter. It captures the counter's packed `{tens, units}` BCD value on a load strobe and time-multiplexes the two digits onto one shared segment bus. The scan includes a one-cycle dead time between digits to suppress ghosting. Invalid BCD nibbles are flagged and shown as a dash.

## Interface
- `SCAN_DIV`, default 1000: number of CK cycles each digit is lit per scan phase; legal range ≥1.
- `CK`  in  1  clock, rising edge
- `RN`  in  1  reset, synchronous, active-low
- `EN`  in  1  display enable; low freezes the scan and blanks the outputs
- `LD`  in  1  load strobe; samples `D` on the rising CK edge
- `D`  in  8  packed BCD, `[7:4]` tens, `[3:0]` units (driven from the counter's `Q`)
- `SEG`  out  7  segments `{g,f,e,d,c,b,a}`, active-high
- `AN`  out  2  digit enables, one-hot active-high: `[0]` units, `[1]` tens
- `ERR`  out  1  high while either latched nibble is >9

## Operation
- **Shadow register**
  - `LD=1` at an edge loads `D` into the 8-bit shadow register.
  - The shadow register holds its value otherwise.
  - Only the shadow register is displayed; `D` is ignored when `LD=0`.
- **FSM states:** `UNITS → DEAD_UT → TENS → DEAD_TU → UNITS`.
  - The prescaler counts 0..`SCAN_DIV-1` in `UNITS` and `TENS`.
  - When the count reaches `SCAN_DIV-1`, the next edge enters the following DEAD state and clears the count.
  - Each DEAD state lasts exactly 1 cycle.
  - Full scan period is `2*SCAN_DIV+2` cycles.
- **Outputs by state**
  - `UNITS`: `AN=01`, `SEG` = decode(units).
  - `TENS`: `AN=10`, `SEG` = decode(tens).
  - DEAD states: `AN=00`, `SEG=00`.
- **Decode table**
  - Digits 0–9: `3F 06 5B 4F 66 6D 7D 07 7F 6F`.
  - Nibbles A–F: `40` (dash).
- **ERR** = (shadow units > 9) or (shadow tens > 9).
- **EN=0**
  - FSM state and prescaler hold.
  - `AN=00`, `SEG=00`.
  - `ERR` and shadow loading remain live.
  - On EN re-assertion the scan resumes in the held state with the held count.

## Timing
- All outputs are registered and decoded from next-state values. Consequently:
  - `AN`/`SEG` change on the same edge the FSM changes state.
  - A `LD` edge updates `SEG` on that same edge if the affected digit is currently lit.
  - `ERR` updates on the `LD` edge.
- **Reset** (`RN=0` at an edge): state `UNITS`, count 0, shadow `0x00`, `AN=01`, `SEG=3F`, `ERR=0`.
  - Reset overrides `EN` and `LD` on the same edge.
  - Reset mid-scan restarts at `UNITS`, count 0.
- `LD` coinciding with a phase transition: both take effect, and the new state shows the new data.
- `SCAN_DIV=1`: each lit phase lasts 1 cycle; period is 4.
- The prescaler is `max(1,$clog2(SCAN_DIV))` bits wide and never exceeds `SCAN_DIV-1`.

## Configuration
- **Macro:** `PES_BCD7SEG_LZB_EN` (leading-zero blanking).
- **Defined:**
  - In `TENS` with shadow tens == 0: `AN=00`, `SEG=00` for the whole phase.
  - Phase timing is unchanged.
  - Tens nibbles 1–F display normally.
- **Undefined:** tens 0 displays as `3F` with `AN=10`.

## Structure
- **Package `pes_bcd7seg_pkg`:**
  - FSM state enum (`UNITS`, `DEAD_UT`, `TENS`, `DEAD_TU`).
  - Segment constants: digit table, `SEG_DASH=7'h40`, `SEG_OFF=7'h00`.
  - `AN` one-hot constants.
- **Sub-module `pes_bcd7seg_dec`:** combinational 4-bit → 7-segment decoder, instantiated once on the selected nibble.
- **Top:** shadow register, prescaler, FSM, output registers.

## Test plan
All scenarios use `SCAN_DIV=4` (period 10).

1. **Reset and idle scan.** Hold `RN=0` for 2 cycles, then release with `EN=1`, `LD=0`.
   - During reset: `AN=01`, `SEG=3F`, `ERR=0`.
   - After release, `AN` sequence: `01`×4, `00`, `10`×4, `00`, repeating.
   - `SEG` shows `3F` in both lit phases (macro undefined).
2. **Load a value.** `LD` with `D=0x47`.
   - Units phase: `SEG=07`.
   - Tens phase: `SEG=66`.
   - `ERR=0`.
   - If loaded mid-`UNITS`, `SEG` switches to `07` on the `LD` edge.
3. **Invalid BCD.** `LD` with `D=0x9A`.
   - `ERR=1` from the `LD` edge.
   - Units phase: `SEG=40`.
   - Tens phase: `SEG=6F`.
   - A subsequent `LD` with `D=0x99` clears `ERR` on its edge.
4. **Leading-zero blanking.** `LD` with `D=0x05`.
   - Macro defined: tens phase gives `AN=00`, `SEG=00` for 4 cycles.
   - Macro undefined: tens phase gives `AN=10`, `SEG=3F`.
   - Units phase: `SEG=6D` in both builds.
5. **Enable freeze.** Drop `EN` at `TENS` count 2 for 5 cycles.
   - While `EN=0`: `AN=00`, `SEG=00`.
   - After re-enable: exactly 2 more `TENS` cycles, then `DEAD_TU`, then `UNITS`.
6. **Reset during load.** `RN=0` together with `LD=1`, `D=0x33`, during `TENS` count 3.
   - Next cycle: `AN=01`, `SEG=3F`, shadow `0x00`, `ERR=0`.
   - Full scan restarts from count 0.

Source files
------------

// File: rtl/pes_bcd7seg_pkg.sv
// pes_bcd7seg_pkg -- shared definitions for the two-digit seven-segment
// scan driver.
//   scan_state_t   : scan FSM states (UNITS, DEAD_UT, TENS, DEAD_TU)
//   SEG_DIGITS     : segment patterns {g,f,e,d,c,b,a} for BCD digits 0-9
//   SEG_DASH/OFF   : dash for invalid nibbles, all segments dark
//   AN_*           : one-hot digit-enable patterns
//   bcd_invalid()  : true for nibbles A-F
package pes_bcd7seg_pkg;

  typedef enum logic [1:0] {
    UNITS   = 2'd0,
    DEAD_UT = 2'd1,
    TENS    = 2'd2,
    DEAD_TU = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [1:0] AN_OFF   = 2'b00;
  localparam logic [1:0] AN_UNITS = 2'b01;
  localparam logic [1:0] AN_TENS  = 2'b10;

  function automatic logic bcd_invalid(input logic [3:0] nibble);
    return nibble > 4'd9;
  endfunction

endpackage

// File: rtl/pes_bcd7seg_dec.sv
// pes_bcd7seg_dec -- combinational BCD nibble to seven-segment decoder.
//   nibble : 4-bit digit to show
//   seg    : segments {g,f,e,d,c,b,a}, active-high; A-F decode to a dash
module pes_bcd7seg_dec
  import pes_bcd7seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    seg = SEG_DASH;
    if (!bcd_invalid(nibble)) seg = SEG_DIGITS[nibble];
  end

endmodule

// File: rtl/pes_bcd7seg_scan.sv
// pes_bcd7seg_scan -- two-digit multiplexed seven-segment display driver.
// Captures a packed {tens, units} BCD byte on LD and scans the two digits
// onto one shared segment bus, with a one-cycle dark gap between digits.
//   SCAN_DIV : cycles each digit stays lit per phase (>= 1)
//   CK       : clock, rising edge
//   RN       : synchronous active-low reset
//   EN       : display enable; low freezes the scan and blanks AN/SEG
//   LD       : load strobe for D
//   D        : packed BCD, [7:4] tens, [3:0] units
//   SEG      : segments {g,f,e,d,c,b,a}, active-high
//   AN       : digit enables, [0] units, [1] tens, active-high
//   ERR      : either latched nibble is above 9
// Build option: define PES_BCD7SEG_LZB_EN to blank a leading zero in the
// tens phase (timing of the scan is unchanged).
module pes_bcd7seg_scan
  import pes_bcd7seg_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       EN,
  input  logic       LD,
  input  logic [7:0] D,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       ERR
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  scan_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    shadow, shadow_nxt;
  logic [3:0]    digit;
  logic [6:0]    dec_seg, seg_nxt;
  logic [1:0]    an_nxt;
  logic          err_nxt;

  // Next-state logic: the prescaler only runs in the lit phases and the
  // dead phases always last one cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shadow_nxt = LD ? D : shadow;
    if (EN) begin
      unique case (state)
        UNITS, TENS: begin
          if (cnt == CNT_LAST) begin
            state_nxt = (state == UNITS) ? DEAD_UT : DEAD_TU;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        DEAD_UT: state_nxt = TENS;
        DEAD_TU: state_nxt = UNITS;
        default: state_nxt = UNITS;
      endcase
    end
  end

  // Outputs are decoded from the next-state values so a phase change or a
  // fresh load reaches the pins on the very edge it happens.
  assign digit = (state_nxt == TENS) ? shadow_nxt[7:4] : shadow_nxt[3:0];

  pes_bcd7seg_dec u_dec (
    .nibble (digit),
    .seg    (dec_seg)
  );

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    if (EN) begin
      if (state_nxt == UNITS) begin
        an_nxt  = AN_UNITS;
        seg_nxt = dec_seg;
      end else if (state_nxt == TENS) begin
`ifdef PES_BCD7SEG_LZB_EN
        if (shadow_nxt[7:4] != 4'd0) begin
          an_nxt  = AN_TENS;
          seg_nxt = dec_seg;
        end
`else
        an_nxt  = AN_TENS;
        seg_nxt = dec_seg;
`endif
      end
    end
  end

  assign err_nxt = bcd_invalid(shadow_nxt[3:0]) | bcd_invalid(shadow_nxt[7:4]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CK) begin
    if (!RN) begin
      state  <= UNITS;
      cnt    <= '0;
      shadow <= 8'h00;
      AN     <= AN_UNITS;
      SEG    <= SEG_DIGITS[0];
      ERR    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
      AN     <= an_nxt;
      SEG    <= seg_nxt;
      ERR    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pes_bcd7seg_scan.sv
// tb_pes_bcd7seg_scan -- scoreboard bench for pes_bcd7seg_scan, SCAN_DIV=4.
// The reference model tracks the position inside the 2*DIV+2 cycle scan
// period and the latched byte; expected outputs are queued at each edge
// and a negedge monitor compares them with the DUT pins.
module tb_pes_bcd7seg_scan;

  localparam int DIV    = 4;
  localparam int PERIOD = 2 * DIV + 2;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       EN = 1'b0;
  logic       LD = 1'b0;
  logic [7:0] D  = 8'h00;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       ERR;

  always #5 CK = ~CK;

  pes_bcd7seg_scan #(.SCAN_DIV(DIV)) dut (
    .CK  (CK),
    .RN  (RN),
    .EN  (EN),
    .LD  (LD),
    .D   (D),
    .SEG (SEG),
    .AN  (AN),
    .ERR (ERR)
  );

  typedef struct {
    logic [1:0] an;
    logic [6:0] seg;
    logic       err;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         pos    = 0;        // position within the scan period
  logic [7:0] shadow_m = 8'h00;

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model and
  // queue what the pins must show until the next edge.
  task automatic step(input logic rn, input logic en, input logic ld,
                      input logic [7:0] d, input string tag);
    exp_t e;
    RN = rn; EN = en; LD = ld; D = d;
    @(posedge CK);
    if (!rn) begin
      pos      = 0;
      shadow_m = 8'h00;
    end else begin
      if (ld) shadow_m = d;
      if (en) pos = (pos + 1) % PERIOD;
    end
    e.tag = tag;
    e.err = (shadow_m[7:4] > 4'd9) || (shadow_m[3:0] > 4'd9);
    e.an  = 2'b00;
    e.seg = 7'h00;
    if (!rn || en) begin
      if (pos < DIV) begin
        e.an  = 2'b01;
        e.seg = seg_tab[shadow_m[3:0]];
      end else if (pos > DIV && pos <= 2 * DIV) begin
        e.an  = 2'b10;
        e.seg = seg_tab[shadow_m[7:4]];
`ifdef PES_BCD7SEG_LZB_EN
        if (shadow_m[7:4] == 4'd0) begin
          e.an  = 2'b00;
          e.seg = 7'h00;
        end
`endif
      end
    end
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 8'h00, "scan");
  endtask

  // Run the scan until the model reaches a given period position.
  task automatic seek(input int target);
    for (int i = 0; i <= PERIOD && pos != target; i++)
      step(1'b1, 1'b1, 1'b0, 8'h00, "seek");
    if (pos != target) begin
      errors++;
      $display("FAIL seek_timeout pos %0d want %0d", pos, target);
    end
  endtask

  always @(negedge CK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, "_an"},  32'(AN),  32'(mon_e.an));
      check({mon_e.tag, "_seg"}, 32'(SEG), 32'(mon_e.seg));
      check({mon_e.tag, "_err"}, 32'(ERR), 32'(mon_e.err));
    end
  end

  initial begin
    // 1. Reset and idle scan
    step(1'b0, 1'b1, 1'b0, 8'h00, "reset");
    step(1'b0, 1'b1, 1'b0, 8'h00, "reset");
    check("reset_an", 32'(AN), 32'h1);
    check("reset_seg", 32'(SEG), 32'h3F);
    check("reset_err", 32'(ERR), 32'h0);
    idle(2 * PERIOD);

    // 2. Load 0x47 in the middle of the units phase
    seek(1);
    step(1'b1, 1'b1, 1'b1, 8'h47, "ld47");
    check("ld47_mid_units_seg", 32'(SEG), 32'h07);
    check("ld47_err", 32'(ERR), 32'h0);
    seek(DIV + 1);
    check("ld47_tens_an", 32'(AN), 32'h2);
    check("ld47_tens_seg", 32'(SEG), 32'h66);

    // 3. Invalid BCD, then a valid reload clears ERR
    step(1'b1, 1'b1, 1'b1, 8'h9A, "ld9a");
    check("ld9a_err", 32'(ERR), 32'h1);
    check("ld9a_tens_seg", 32'(SEG), 32'h6F);
    seek(0);
    check("ld9a_units_seg", 32'(SEG), 32'h40);
    idle(3);
    step(1'b1, 1'b1, 1'b1, 8'h99, "ld99");
    check("ld99_err", 32'(ERR), 32'h0);

    // 4. Leading zero
    step(1'b1, 1'b1, 1'b1, 8'h05, "ld05");
    seek(0);
    check("ld05_units_seg", 32'(SEG), 32'h6D);
    seek(DIV + 1);
`ifdef PES_BCD7SEG_LZB_EN
    check("ld05_tens_an", 32'(AN), 32'h0);
    check("ld05_tens_seg", 32'(SEG), 32'h00);
`else
    check("ld05_tens_an", 32'(AN), 32'h2);
    check("ld05_tens_seg", 32'(SEG), 32'h3F);
`endif

    // 5. Enable freeze at TENS count 2, with a load while frozen
    step(1'b1, 1'b1, 1'b1, 8'h28, "ld28");
    seek(DIV + 1 + 2);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, (i == 2), 8'hC3, "freeze");
      check("freeze_an", 32'(AN), 32'h0);
      check("freeze_seg", 32'(SEG), 32'h00);
    end
    check("freeze_err_live", 32'(ERR), 32'h1);
    idle(PERIOD + 2);

    // 6. Reset together with a load during TENS count 3
    step(1'b1, 1'b1, 1'b1, 8'h47, "ld47b");
    seek(DIV + 1 + 3);
    step(1'b0, 1'b1, 1'b1, 8'h33, "rst_ld");
    check("rst_ld_an", 32'(AN), 32'h1);
    check("rst_ld_seg", 32'(SEG), 32'h3F);
    check("rst_ld_err", 32'(ERR), 32'h0);
    idle(PERIOD + 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 5) == 0), 8'($urandom), "rand");

    @(negedge CK);
    @(negedge CK);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
